// File: rtl/nn_seq_engine.sv
// Sequential multi-layer fully-connected inference engine: NUM_MULTS-lane signed MAC
// array, ReLU hidden layers, saturated output scores and argmax. Optional NN_ABORT_EN adds an abort input.
module nn_seq_engine #(
  parameter int NUM_MULTS   = 15,
  parameter int DATA_W      = 16,
  parameter int ACC_W       = 40,
  parameter int FRAC_BITS   = 12,
  parameter int IN_LEN      = 256,
  parameter int NUM_LAYERS  = 3,
  parameter int NUM_CLASSES = 10,
  parameter int ADR_W       = 9
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
`ifdef NN_ABORT_EN
  input  logic                             abort,
`endif
  output logic                             busy,
  output logic                             done,
  output logic [ADR_W-1:0]                 img_addr,
  input  logic [7:0]                       img_data,
  output logic [$clog2(NUM_LAYERS)-1:0]    w_layer,
  output logic [ADR_W-1:0]                 w_addr,
  input  logic [NUM_MULTS*DATA_W-1:0]      w_data,
  output logic [NUM_CLASSES*DATA_W-1:0]    scores,
  output logic [3:0]                       class_idx
);

  localparam int LW = $clog2(NUM_LAYERS);
  localparam int IW = $clog2(NUM_MULTS);
  localparam int PW = 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE, S_MAC, S_DRAIN, S_WB, S_ARGMAX, S_DONE
  } state_t;

  state_t                   r_state;
  logic                     r_busy;
  logic                     r_done;
  logic [ADR_W-1:0]         r_row;
  logic [ADR_W-1:0]         r_row_d;
  logic [ADR_W-1:0]         r_img_addr;
  logic [LW-1:0]            r_layer;
  logic                     r_acc_en;
  logic signed [ACC_W-1:0]  r_acc    [NUM_MULTS];
  logic signed [DATA_W-1:0] r_act    [NUM_MULTS];
  logic signed [DATA_W-1:0] r_scores [NUM_CLASSES];
  logic [3:0]               r_arg_i;
  logic [3:0]               r_best_idx;
  logic signed [DATA_W-1:0] r_best_val;
  logic [3:0]               r_class_idx;

  logic signed [DATA_W-1:0] w_operand;
  logic [IW-1:0]            w_act_idx;
  logic signed [DATA_W-1:0] w_weight [NUM_MULTS];
  logic signed [PW-1:0]     w_prod   [NUM_MULTS];
  logic signed [DATA_W-1:0] w_sat    [NUM_MULTS];
  logic [ADR_W-1:0]         w_last_row;
  logic                     w_last_layer;
  logic signed [DATA_W-1:0] w_cur;
  logic                     w_take;
  logic                     w_abort;

`ifdef NN_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Arithmetic shift down to the Q format, then clamp to the DATA_W signed range.
  function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    logic [ACC_W-DATA_W:0]   top;
    s   = a >>> FRAC_BITS;
    top = s[ACC_W-1:DATA_W-1];
    if ((&top) || !(|top))     sat_shift = s[DATA_W-1:0];
    else if (top[ACC_W-DATA_W]) sat_shift = {1'b1, {(DATA_W-1){1'b0}}};
    else                        sat_shift = {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  // Operand follows the row index registered alongside the ROM's one-cycle latency.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    w_act_idx = IW'(r_row_d - ADR_W'(1));
    if (r_row_d == '0)       w_operand = DATA_W'(1 << FRAC_BITS);
    else if (r_layer == '0)  w_operand = {{(DATA_W-8){1'b0}}, img_data} << (FRAC_BITS - 8);
    else                     w_operand = r_act[w_act_idx];
  end

  always_comb begin
    for (int i = 0; i < NUM_MULTS; i++) begin
      w_weight[i] = w_data[DATA_W*(i+1)-1 -: DATA_W];
      w_prod[i]   = PW'(w_operand) * PW'(w_weight[i]);
      w_sat[i]    = sat_shift(r_acc[i]);
    end
  end

  assign w_last_row   = (r_layer == '0) ? ADR_W'(IN_LEN) : ADR_W'(NUM_MULTS);
  assign w_last_layer = (r_layer == LW'(NUM_LAYERS - 1));
  assign w_cur        = r_scores[r_arg_i];
  assign w_take       = (r_arg_i == '0) || (w_cur > r_best_val);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_row       <= '0;
      r_row_d     <= '0;
      r_img_addr  <= '0;
      r_layer     <= '0;
      r_acc_en    <= 1'b0;
      r_arg_i     <= '0;
      r_best_idx  <= '0;
      r_best_val  <= '0;
      r_class_idx <= '0;
      // NOTE: the activation buffer and score lanes are flop arrays, so they take the reset like any register.
      for (int i = 0; i < NUM_MULTS; i++) begin
        r_acc[i] <= '0;
        r_act[i] <= '0;
      end
      for (int c = 0; c < NUM_CLASSES; c++) r_scores[c] <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignment; later assignments below override the accumulate.
      r_row_d  <= r_row;
      r_acc_en <= (r_state == S_MAC);
      if (r_acc_en) begin
        for (int i = 0; i < NUM_MULTS; i++) r_acc[i] <= r_acc[i] + ACC_W'(w_prod[i]);
      end

      if (w_abort && (r_state != S_IDLE)) begin
        r_state  <= S_IDLE;
        r_busy   <= 1'b0;
        r_done   <= 1'b0;
        r_acc_en <= 1'b0;
        for (int i = 0; i < NUM_MULTS; i++) r_acc[i] <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !w_abort) begin
              r_state    <= S_MAC;
              r_busy     <= 1'b1;
              r_layer    <= '0;
              r_row      <= '0;
              r_img_addr <= '0;
              for (int i = 0; i < NUM_MULTS; i++) r_acc[i] <= '0;
            end
          end
          S_MAC: begin
            if (r_row == w_last_row) begin
              r_state <= S_DRAIN;
            end else begin
              r_row <= r_row + ADR_W'(1);
              if (r_layer == '0) r_img_addr <= r_row;
            end
          end
          S_DRAIN: r_state <= S_WB;
          S_WB: begin
            if (!w_last_layer) begin
              for (int i = 0; i < NUM_MULTS; i++) begin
                r_act[i] <= w_sat[i][DATA_W-1] ? '0 : w_sat[i];
                r_acc[i] <= '0;
              end
              r_layer <= r_layer + LW'(1);
              r_row   <= '0;
              r_state <= S_MAC;
            end else begin
              for (int c = 0; c < NUM_CLASSES; c++) r_scores[c] <= w_sat[c];
              r_arg_i <= '0;
              r_state <= S_ARGMAX;
            end
          end
          S_ARGMAX: begin
            if (w_take) begin
              r_best_val <= w_cur;
              r_best_idx <= r_arg_i;
            end
            if (r_arg_i == 4'(NUM_CLASSES - 1)) begin
              r_class_idx <= w_take ? r_arg_i : r_best_idx;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_arg_i <= r_arg_i + 4'd1;
            end
          end
          S_DONE: begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign img_addr  = r_img_addr;
  assign w_layer   = r_layer;
  assign w_addr    = r_row;
  assign class_idx = r_class_idx;

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_scores
    assign scores[DATA_W*(g+1)-1 -: DATA_W] = r_scores[g];
  end

endmodule

// File: tb/tb_nn_seq_engine.sv
// Directed bench for nn_seq_engine with behavioural image/weight ROMs and hand-computed expectations.
module tb_nn_seq_engine;
  localparam int NM  = 15;
  localparam int DW  = 16;
  localparam int NC  = 10;
  localparam int NL  = 3;
  localparam int IL  = 256;
  localparam int LAT = 306;

  logic clk;
  logic reset;
  logic start;
  logic abort;
  logic busy, done;
  logic [8:0]       img_addr, w_addr;
  logic [7:0]       img_data;
  logic [1:0]       w_layer;
  logic [NM*DW-1:0] w_data;
  logic [NC*DW-1:0] scores;
  logic [3:0]       class_idx;

  logic [7:0]       irom [IL];
  logic [NM*DW-1:0] wrom [NL][IL+1];

  int total = 0;
  int bad   = 0;

  nn_seq_engine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef NN_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .img_addr  (img_addr),
    .img_data  (img_data),
    .w_layer   (w_layer),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .scores    (scores),
    .class_idx (class_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    img_data <= irom[img_addr[7:0]];
    if (int'(w_layer) < NL && int'(w_addr) <= IL) w_data <= wrom[w_layer][w_addr];
    else                                          w_data <= '0;
  end

  function automatic logic [NC*DW-1:0] two_lanes(input int a, input logic [15:0] va,
                                                 input int b, input logic [15:0] vb);
    logic [NC*DW-1:0] v;
    v = '0;
    v[a*DW +: DW] = va;
    v[b*DW +: DW] = vb;
    return v;
  endfunction

  task automatic clear_roms();
    for (int i = 0; i < IL; i++) irom[i] = 8'd0;
    for (int l = 0; l < NL; l++)
      for (int r = 0; r <= IL; r++) wrom[l][r] = '0;
  endtask

  task automatic set_w(input int l, input int r, input int lane, input logic [15:0] v);
    wrom[l][r][lane*DW +: DW] = v;
  endtask

  task automatic load_identity(input int l);
    for (int i = 0; i < NM; i++) set_w(l, i + 1, i, 16'h1000);
  endtask

  // Pixel 0 = 255 routed through lane 0 of every layer; output lane 7 = bias 0x2000 + lane-0 value.
  task automatic load_propagate();
    clear_roms();
    irom[0] = 8'd255;
    set_w(0, 1, 0, 16'h1000);
    load_identity(1);
    load_identity(2);
    set_w(2, 1, 7, 16'h1000);
    set_w(2, 0, 7, 16'h2000);
  endtask

  // Start pulse, then count cycles until done; optional extra start pulse and abort at given cycles.
  task automatic run(input int pulse_cyc, input int abort_cyc, output int lat);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 1;
    while (!done && lat < 1000 && !(abort_cyc > 0 && lat > abort_cyc)) begin
      start = (lat == pulse_cyc);
      abort = (lat == abort_cyc);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (scores !== '0) begin bad++; $display("FAIL reset_scores got=%h exp=0", scores); end
    total++; if (class_idx !== 4'd0) begin bad++; $display("FAIL reset_class got=%0d exp=0", class_idx); end
    total++; if ({img_addr, w_addr, w_layer} !== '0) begin
      bad++; $display("FAIL reset_addr got=%h/%h/%h exp=0", img_addr, w_addr, w_layer);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int lat;
    clear_roms();
    run(-1, -1, lat);
    total++; if (lat != LAT) begin bad++; $display("FAIL zero_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (scores !== '0) begin bad++; $display("FAIL zero_scores got=%h exp=0", scores); end
    total++; if (class_idx !== 4'd0) begin bad++; $display("FAIL zero_class got=%0d exp=0", class_idx); end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_done_pulse got done=%b busy=%b exp 0/0", done, busy);
    end
  endtask

  task automatic test_propagate();
    int lat;
    load_propagate();
    run(-1, -1, lat);
    total++; if (lat != LAT) begin bad++; $display("FAIL prop_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (scores !== two_lanes(0, 16'h0FF0, 7, 16'h2FF0)) begin
      bad++; $display("FAIL prop_scores got=%h exp=%h", scores, two_lanes(0, 16'h0FF0, 7, 16'h2FF0));
    end
    total++; if (class_idx !== 4'd7) begin bad++; $display("FAIL prop_class got=%0d exp=7", class_idx); end
  endtask

  // Negative layer-0 biases: hidden lanes clip to 0; equal output biases on lanes 2 and 7 tie to 2.
  task automatic test_relu();
    int lat;
    load_propagate();
    for (int i = 0; i < NM; i++) set_w(0, 0, i, 16'hF000);
    set_w(2, 0, 2, 16'h2000);
    run(-1, -1, lat);
    total++; if (scores !== two_lanes(2, 16'h2000, 7, 16'h2000)) begin
      bad++; $display("FAIL relu_scores got=%h exp=%h", scores, two_lanes(2, 16'h2000, 7, 16'h2000));
    end
    total++; if (class_idx !== 4'd2) begin bad++; $display("FAIL relu_tie_class got=%0d exp=2", class_idx); end
  endtask

  task automatic test_saturate();
    int lat;
    clear_roms();
    for (int i = 0; i < IL; i++) begin
      irom[i] = 8'd255;
      set_w(0, i + 1, 0, 16'h7FFF);
    end
    load_identity(1);
    load_identity(2);
    set_w(2, 0, 1, 16'h8000);
    set_w(2, 1, 1, 16'h8000);
    run(-1, -1, lat);
    total++; if (scores !== two_lanes(0, 16'h7FFF, 1, 16'h8000)) begin
      bad++; $display("FAIL sat_scores got=%h exp=%h", scores, two_lanes(0, 16'h7FFF, 1, 16'h8000));
    end
    total++; if (class_idx !== 4'd0) begin bad++; $display("FAIL sat_class got=%0d exp=0", class_idx); end
  endtask

  task automatic test_back_to_back();
    int lat;
    load_propagate();
    run(50, -1, lat);
    total++; if (lat != LAT) begin bad++; $display("FAIL busy_start_latency got=%0d exp=%0d", lat, LAT); end
    start = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got busy=%b done=%b exp 0/0", busy, done);
    end
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got busy=%b exp=1", busy); end
    lat = 1;
    while (!done && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    total++; if (lat != LAT) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (class_idx !== 4'd7) begin bad++; $display("FAIL b2b_class got=%0d exp=7", class_idx); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int pulses;
    load_propagate();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (99) @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    total++; if (scores !== '0 || class_idx !== 4'd0) begin
      bad++; $display("FAIL midreset_result got=%h/%0d exp=0/0", scores, class_idx);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    count_done(400, pulses);
    total++; if (pulses != 0) begin bad++; $display("FAIL midreset_no_done got=%0d exp=0", pulses); end
    run(-1, -1, lat);
    total++; if (lat != LAT || class_idx !== 4'd7) begin
      bad++; $display("FAIL midreset_rerun got lat=%0d class=%0d exp %0d/7", lat, class_idx, LAT);
    end
    total++; if (scores !== two_lanes(0, 16'h0FF0, 7, 16'h2FF0)) begin
      bad++; $display("FAIL midreset_scores got=%h exp=%h", scores, two_lanes(0, 16'h0FF0, 7, 16'h2FF0));
    end
  endtask

`ifdef NN_ABORT_EN
  task automatic test_abort();
    int lat;
    int pulses;
    // Previous result is the propagate pattern (class 7); the aborted run would have produced class 2.
    load_propagate();
    for (int i = 0; i < NM; i++) set_w(0, 0, i, 16'hF000);
    set_w(2, 0, 2, 16'h2000);
    run(-1, 270, lat);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    count_done(400, pulses);
    total++; if (pulses != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
    total++; if (class_idx !== 4'd7 || scores !== two_lanes(0, 16'h0FF0, 7, 16'h2FF0)) begin
      bad++; $display("FAIL abort_hold got=%h/%0d exp=%h/7", scores, class_idx, two_lanes(0, 16'h0FF0, 7, 16'h2FF0));
    end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_priority got busy=%b exp=0", busy); end
    run(-1, -1, lat);
    total++; if (lat != LAT || class_idx !== 4'd2) begin
      bad++; $display("FAIL abort_rerun got lat=%0d class=%0d exp %0d/2", lat, class_idx, LAT);
    end
  endtask
`endif

  initial begin
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
    clear_roms();
    test_reset();
    test_zero();
    test_propagate();
    test_relu();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
`ifdef NN_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nn_seq_engine.md
Name: nn_seq_engine

Overview:
- Parametrised, start/done-controlled successor to the fixed 3-layer feedforward core.
- Runs NUM_LAYERS fully-connected layers on a NUM_MULTS-lane signed MAC array. Reads the image and per-layer weight rows from external synchronous ROMs and holds hidden activations in an internal buffer.
- Produces saturated final-layer scores plus an argmax class index.
- Sits between the image store/decimators and the MCU-facing result interface.

Parameters:
- NUM_MULTS, 15, MAC lanes = hidden-layer width (HID_LEN).
- DATA_W, 16, signed activation/weight width.
- ACC_W, 40, signed accumulator width per lane.
- FRAC_BITS, 12, fractional bits of the activation/weight Q format.
- IN_LEN, 256, image pixels (layer-0 inputs).
- NUM_LAYERS, 3, layer count (≥2); the last layer is the output layer.
- NUM_CLASSES, 10, output lanes used (≤NUM_MULTS).
- ADR_W, 9, ROM address width (≥ clog2(IN_LEN+1)).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin inference; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE is exited.
- done  out  1  one-cycle pulse when scores and class_idx are valid.
- img_addr  out  ADR_W  image ROM address.
- img_data  in  8  unsigned pixel; 1-cycle synchronous latency.
- w_layer  out  clog2(NUM_LAYERS)  weight ROM layer select.
- w_addr  out  ADR_W  weight row address; row 0 = bias.
- w_data  in  NUM_MULTS*DATA_W  weight row, lane i at bits [DATA_W*(i+1)-1 -: DATA_W]; 1-cycle latency.
- scores  out  NUM_CLASSES*DATA_W  final-layer outputs, same packing as w_data.
- class_idx  out  4  argmax of scores.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - busy, done, img_addr, w_layer, w_addr, scores, class_idx, accumulators and activation buffer all go to 0.
  - Reset mid-inference aborts immediately. No partial result becomes visible.
- States: IDLE → MAC → DRAIN → WB → (MAC of next layer | ARGMAX) → DONE → IDLE.
- IDLE:
  - start=1 moves to MAC for layer 0, clears all accumulators and sets row=0.
  - start is ignored in every other state.
- MAC:
  - Each cycle issues w_layer=L and w_addr=row.
  - Layer 0 also issues img_addr=row-1 (don't-care for row 0).
  - R(L) rows are issued: R(0)=IN_LEN+1; R(L>0)=NUM_MULTS+1.
  - row increments by 1 per cycle; after row R(L)-1 the state goes to DRAIN.
- Operand selection, applied one cycle after the address, via a registered row index:
  - Row 0 (bias) uses operand 1<<FRAC_BITS.
  - Layer 0 otherwise uses zero-extended img_data << (FRAC_BITS-8).
  - Layers >0 use activation buffer entry row-1.
  - Every lane accumulates acc += sext(operand × lane weight), a full 2*DATA_W signed product sign-extended to ACC_W, wrapping.
- DRAIN: one cycle; the final product is accumulated.
- WB:
  - Each lane computes v = sat_DATA_W(acc >>> FRAC_BITS): clamp to 0x7FFF / 0x8000 for DATA_W=16.
  - Hidden layers (L<NUM_LAYERS-1): buffer[i] = v<0 ? 0 : v (ReLU). Accumulators clear, L increments, row=0, next state MAC.
  - Output layer: scores lanes 0..NUM_CLASSES-1 = v with no ReLU; next state ARGMAX.
  - The buffer is updated only in WB, so a layer never reads its own outputs.
- ARGMAX:
  - NUM_CLASSES cycles, one signed compare per cycle.
  - Strict greater-than, so ties resolve to the lowest index.
  - class_idx is registered at exit.
- DONE: done=1 for exactly one cycle, busy=1; returns to IDLE.
- Hold: scores and class_idx hold their values until the next output-layer WB or a reset.
- Latency: start sampled at edge 0 → done high in cycle Σ(R(L)+2) + NUM_CLASSES + 1. Defaults: 259+18+18+10+1 = 306.
- Back-to-back: start asserted during DONE is ignored; start in the following IDLE cycle is accepted.

Optional Feature:
- Macro NN_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in any non-IDLE state forces IDLE on the next edge and clears busy and accumulators.
  - done is not pulsed; scores and class_idx keep their previous values.
  - abort in IDLE has no effect, and abort takes priority over a coincident start.
- Undefined: port absent; an inference runs to completion or reset only.

Test Plan:
- All pixels 0, all weights 0, all biases 0 → done in cycle 306, scores all 0, class_idx=0 (tie rule).
- Pixel[0]=255, rest 0, layer-0 lane0 row1 weight=0x1000 (1.0), identity hidden layers, output bias lane7=0x2000 → class_idx=7, scores lane7=0x2000 + propagated lane0 value.
- Layer-0 biases = −0x1000 on all lanes → hidden activations clamp to 0 (ReLU); scores equal output biases only.
- Weights forcing acc >>> 12 > 32767 → WB writes 0x7FFF; forcing < −32768 → output score 0x8000.
- Reset driven low at cycle 100 of layer 0 → busy=0, done never pulses, scores=0. A fresh start after release completes with the correct result.
- NN_ABORT_EN defined: abort at cycle 270 → IDLE next cycle, no done, previous class_idx retained. Start while busy (cycle 50) → ignored, latency unchanged.
